cache_access_ctrl: RTL and testbench
====================================

// Module: cache_access_ctrl
// PURPOSE
//  Sequences all accesses to the direct-mapped cache and its backing RAM, and shares them between
//  N_REQ requesters using round-robin arbitration. Handles lookup, write-through, miss fetch and fill.
//  Sits between the requesters (e.g. fetch and load/store ports) and the cache + RAM pair.
//  Exactly one transaction is in flight at a time.
// PARAMETERS
//  N_REQ     2     number of requesters (2..4)
//  ADDR_W    32    requester address width
//  DATA_W    32    data width
//  RAM_DEPTH 4096  RAM words; mem_addr = req_addr % RAM_DEPTH
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              reset; synchronous, active-high
//  req_valid  in   N_REQ          request pending, one bit per requester
//  req_write  in   N_REQ          1 = write, 0 = read
//  req_addr   in   N_REQ*ADDR_W   packed addresses; requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   N_REQ*DATA_W   packed write data
//  req_ready  out  N_REQ          one-hot accept pulse
//  rsp_valid  out  N_REQ          one-hot completion pulse
//  rsp_rdata  out  DATA_W         read data; valid with rsp_valid
//  c_lookup   out  1              cache tag check, using c_addr
//  c_addr     out  ADDR_W         address to cache
//  c_hit      in   1              valid && tag match; sampled in LOOKUP
//  c_rdata    in   DATA_W         cache line data; sampled in LOOKUP
//  c_wr       out  1              1-cycle pulse: overwrite the line on a write hit
//  c_fill     out  1              1-cycle pulse: allocate the line (valid=1, tag, data)
//  c_wdata    out  DATA_W         data for c_wr / c_fill
//  mem_req    out  1              RAM request; held until mem_ack
//  mem_we     out  1              RAM write enable
//  mem_addr   out  log2(RAM_DEPTH) RAM word address
//  mem_wdata  out  DATA_W         RAM write data
//  mem_ack    in   1              RAM done; 1-cycle pulse
//  mem_rdata  in   DATA_W         RAM read data; valid with mem_ack
//  hit_cnt    out  16             read-hit count (feature-gated)
//  miss_cnt   out  16             read-miss count (feature-gated)
// BEHAVIOUR
//  Reset: state IDLE, rr pointer = 0. All outputs 0, including rdata and counters.
//   A transaction in progress is abandoned; mem_req drops in the cycle after rst is sampled.
//  IDLE:
//   - Any req_valid: grant the first requester at or after the rr pointer (wrapping).
//   - req_ready[g] = 1 that same cycle. Latch write, address and data.
//   - Pointer becomes (g+1) % N_REQ. Go to LOOKUP.
//  LOOKUP (1 cycle, c_lookup = 1):
//   - Read hit: rsp_rdata <= c_rdata; go to RESP.
//   - Read miss: go to MEM_RD.
//   - Write: if c_hit, pulse c_wr with the write data. Go to MEM_WR (write-through, no allocate).
//  MEM_RD: mem_req = 1, mem_we = 0 until mem_ack.
//   - On mem_ack: rsp_rdata <= mem_rdata; go to FILL.
//  MEM_WR: mem_req = 1, mem_we = 1 until mem_ack; then go to RESP.
//  FILL (1 cycle): c_fill = 1, c_wdata = fetched data; go to RESP.
//  RESP (1 cycle): rsp_valid[g] = 1; go to IDLE.
//  Latency from accept: read hit 2 cycles to rsp_valid; read miss 3 + L; write 2 + L,
//   where L = cycles from mem_req rising to mem_ack (L >= 1).
//  Handshake:
//   - Requesters hold req_valid and their fields stable until req_ready.
//   - No req_ready outside IDLE; new requests wait.
//   - A requester may raise a new request in its own RESP cycle. It is eligible next IDLE cycle.
//  Edge cases:
//   - mem_ack outside MEM_* states is ignored.
//   - Address bits above log2(RAM_DEPTH) are dropped (wrap-around).
//   - A lone requester is granted regardless of the pointer.
// CONFIGURATION
//  CACHE_ACCESS_STATS_EN defined:
//   - hit_cnt / miss_cnt increment on read hit / read miss in LOOKUP.
//   - 16-bit, saturate at 0xFFFF, cleared by rst.
//  Not defined: counters absent; hit_cnt and miss_cnt tied to 0.
// STRUCTURE
//  Package cache_access_pkg:
//   - state enum {IDLE, LOOKUP, MEM_RD, MEM_WR, FILL, RESP}
//   - RAM_DEPTH, DATA_W, ADDR_W defaults; rr pointer width function.
//  Sub-module rr_arbiter:
//   - N_REQ request vector + pointer -> one-hot grant + next pointer.
//   - Purely combinational; the pointer register stays in the parent.
// TESTING
//  1. rst for 2 cycles mid-MEM_RD (L = 5) -> mem_req = 0 next cycle, state IDLE, all outputs 0.
//  2. Req0 reads 0x040, cache miss, mem_rdata = 0xDEADBEEF, L = 3
//     -> c_fill with 0xDEADBEEF, rsp_valid[0] 6 cycles after accept.
//     Re-read of 0x040 with c_hit = 1 -> rsp_valid 2 cycles after accept, same data, no mem_req.
//  3. Req0 and req1 both valid continuously, all hits -> grants alternate 0,1,0,1; none starves.
//  4. Req1 writes 0x1234 to 0x1040 with c_hit = 1 -> c_wr pulse, mem_we = 1, mem_addr = 0x040.
//     With c_hit = 0 -> no c_wr and no c_fill.
//  5. Address 0xFFFF_F003 -> mem_addr = 0xFF... truncated to 12 bits = 0x003.
//  6. CACHE_ACCESS_STATS_EN, 3 read hits + 2 read misses -> hit_cnt = 3, miss_cnt = 2.
//     Forced to 0xFFFF then one more read hit -> hit_cnt stays 0xFFFF.

Source files
------------

// File: rtl/cache_access_pkg.sv
// Shared types and defaults for the cache access controller: FSM state encoding,
// default widths and the round-robin pointer width helper.
package cache_access_pkg;

   localparam int N_REQ_DEF     = 2;
   localparam int ADDR_W_DEF    = 32;
   localparam int DATA_W_DEF    = 32;
   localparam int RAM_DEPTH_DEF = 4096;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      MEM_RD = 3'd2,
      MEM_WR = 3'd3,
      FILL   = 3'd4,
      RESP   = 3'd5
   } state_t;

   // A pointer over n requesters needs at least one bit even when n is 1.
   function automatic int ptr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cache_access_if.sv
// Bundle of requester, cache and RAM signals around the cache access controller.
// The slave modport is the controller; the master modport is its environment.
interface cache_access_if #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MEM_AW = 12
);
   // Requester handshake: a requester raises req_valid[i] with stable write/addr/wdata and
   // holds them until the single-cycle req_ready[i] pulse, which is the acceptance (the
   // request is taken on that clock edge). Completion is the single-cycle rsp_valid[i] pulse,
   // with rsp_rdata valid in the same cycle. The RAM side holds mem_req until a 1-cycle mem_ack.
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_write;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]       rsp_rdata;

   logic                    c_lookup;
   logic [ADDR_W-1:0]       c_addr;
   logic                    c_hit;
   logic [DATA_W-1:0]       c_rdata;
   logic                    c_wr;
   logic                    c_fill;
   logic [DATA_W-1:0]       c_wdata;

   logic                    mem_req;
   logic                    mem_we;
   logic [MEM_AW-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic                    mem_ack;
   logic [DATA_W-1:0]       mem_rdata;

   logic [15:0]             hit_cnt;
   logic [15:0]             miss_cnt;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      input  c_hit, c_rdata, mem_ack, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata,
      output c_lookup, c_addr, c_wr, c_fill, c_wdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output hit_cnt, miss_cnt
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      output c_hit, c_rdata, mem_ack, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata,
      input  c_lookup, c_addr, c_wr, c_fill, c_wdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  hit_cnt, miss_cnt
   );

endinterface

// File: rtl/cache_access_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after ptr (wrapping)
// and reports the pointer value that follows the winner.
module rr_arbiter
   import cache_access_pkg::*;
#(
   parameter int  N_REQ = 2,
   localparam int PW    = ptr_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PW-1:0]    grant_idx,
   output logic [PW-1:0]    next_ptr,
   output logic             found
);

   int idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      next_ptr  = ptr;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
            next_ptr   = PW'((idx + 1) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/cache_access_ctrl.sv
// Sequences lookup, write-through, miss fetch and fill for one transaction at a time,
// shared round-robin between N_REQ requesters. Read hit/miss counters exist only with CACHE_ACCESS_STATS_EN.
module cache_access_ctrl
   import cache_access_pkg::*;
#(
   parameter int  N_REQ     = N_REQ_DEF,
   parameter int  ADDR_W    = ADDR_W_DEF,
   parameter int  DATA_W    = DATA_W_DEF,
   parameter int  RAM_DEPTH = RAM_DEPTH_DEF,
   localparam int MEM_AW    = $clog2(RAM_DEPTH),
   localparam int PW        = ptr_w(N_REQ)
) (
   input  logic          clk,
   input  logic          rst,
   cache_access_if.slave bus,
   output state_t        dbg_state
);

   state_t            state, state_n;
   logic [PW-1:0]     ptr, next_ptr, grant_idx;
   logic [N_REQ-1:0]  grant, gnt_q;
   logic              found, accept, rd_hit;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;

   logic [N_REQ-1:0]  ready_c, rsp_c;
   logic              lookup_c, c_wr_c, c_fill_c, mem_req_c, mem_we_c;
   logic [DATA_W-1:0] c_wdata_c;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req       (bus.req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .next_ptr  (next_ptr),
      .found     (found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         gnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            ptr     <= next_ptr;
            gnt_q   <= grant;
            write_q <= bus.req_write[grant_idx];
            addr_q  <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
            wdata_q <= bus.req_wdata[grant_idx*DATA_W +: DATA_W];
         end
         if (rd_hit)
            rdata_q <= bus.c_rdata;
         // The fetched word doubles as the fill data and the response data.
         if (state == MEM_RD && bus.mem_ack)
            rdata_q <= bus.mem_rdata;
      end
   end

   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      rd_hit    = 1'b0;
      ready_c   = '0;
      rsp_c     = '0;
      lookup_c  = 1'b0;
      c_wr_c    = 1'b0;
      c_fill_c  = 1'b0;
      c_wdata_c = '0;
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      case (state)
         IDLE: begin
            if (found && !rst) begin
               accept  = 1'b1;
               ready_c = grant;
               state_n = LOOKUP;
            end
         end
         LOOKUP: begin
            lookup_c = 1'b1;
            if (write_q) begin
               // Write-through without allocate: only refresh a line that is already present.
               if (bus.c_hit) begin
                  c_wr_c    = 1'b1;
                  c_wdata_c = wdata_q;
               end
               state_n = MEM_WR;
            end else if (bus.c_hit) begin
               rd_hit  = 1'b1;
               state_n = RESP;
            end else begin
               state_n = MEM_RD;
            end
         end
         MEM_RD: begin
            mem_req_c = 1'b1;
            if (bus.mem_ack)
               state_n = FILL;
         end
         MEM_WR: begin
            mem_req_c = 1'b1;
            mem_we_c  = 1'b1;
            if (bus.mem_ack)
               state_n = RESP;
         end
         FILL: begin
            c_fill_c  = 1'b1;
            c_wdata_c = rdata_q;
            state_n   = RESP;
         end
         RESP: begin
            rsp_c   = gnt_q;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.req_ready = ready_c;
   assign bus.rsp_valid = rsp_c;
   assign bus.rsp_rdata = rdata_q;
   assign bus.c_lookup  = lookup_c;
   assign bus.c_addr    = addr_q;
   assign bus.c_wr      = c_wr_c;
   assign bus.c_fill    = c_fill_c;
   assign bus.c_wdata   = c_wdata_c;
   assign bus.mem_req   = mem_req_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_addr  = addr_q[MEM_AW-1:0];
   assign bus.mem_wdata = wdata_q;
   assign dbg_state     = state;

`ifdef CACHE_ACCESS_STATS_EN
   logic [15:0] hit_cnt_q, miss_cnt_q;
   logic        rd_miss;

   assign rd_miss = (state == LOOKUP) && !write_q && !bus.c_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (rd_hit && hit_cnt_q != 16'hFFFF)
            hit_cnt_q <= hit_cnt_q + 16'd1;
         if (rd_miss && miss_cnt_q != 16'hFFFF)
            miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   assign bus.hit_cnt  = hit_cnt_q;
   assign bus.miss_cnt = miss_cnt_q;
`else
   assign bus.hit_cnt  = '0;
   assign bus.miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Self-checking bench for cache_access_ctrl: RAM latency model, side-effect monitor and a
// response scoreboard queue; counter checks follow CACHE_ACCESS_STATS_EN.
module tb_cache_access_ctrl;
   import cache_access_pkg::*;

   localparam int N_REQ  = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MEM_AW = 12;
   localparam int SB_W   = 1 + 2 + DATA_W;   // {check_data, requester, data}

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t dbg_state;

   cache_access_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) bus ();

   cache_access_ctrl #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_DEPTH(4096)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [SB_W-1:0] exp_q[$];
   int exp_ptr  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: ack in the L-th cycle of mem_req; off-cycle data is deliberately wrong
   int          mem_lat  = 1;
   logic [31:0] mem_word = 32'h0;
   int          mem_cnt  = 0;

   always @(negedge clk) begin
      if (bus.mem_req) begin
         mem_cnt = mem_cnt + 1;
         if (mem_cnt == mem_lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_word;
         end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = ~mem_word;
         end
      end else begin
         mem_cnt       = 0;
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = ~mem_word;
      end
   end

   // side-effect monitor (only this process writes these)
   int          n_c_wr = 0, n_c_fill = 0, n_mem_req = 0, n_mem_we = 0, n_rsp = 0;
   logic [31:0] c_wr_data = 0, fill_data = 0, mem_wdata_seen = 0;
   logic [11:0] mem_addr_seen = 0;

   always @(negedge clk) begin
      #2;
      if (bus.c_wr) begin
         n_c_wr    = n_c_wr + 1;
         c_wr_data = bus.c_wdata;
      end
      if (bus.c_fill) begin
         n_c_fill  = n_c_fill + 1;
         fill_data = bus.c_wdata;
      end
      if (bus.mem_req) begin
         n_mem_req      = n_mem_req + 1;
         mem_addr_seen  = bus.mem_addr;
         mem_wdata_seen = bus.mem_wdata;
         if (bus.mem_we) n_mem_we = n_mem_we + 1;
      end
      if (bus.rsp_valid != '0) n_rsp = n_rsp + 1;
   end

   function automatic logic [190:0] all_outputs();
      return {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.c_lookup, bus.c_addr, bus.c_wr,
              bus.c_fill, bus.c_wdata, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
              bus.hit_cnt, bus.miss_cnt};
   endfunction

   // driver: one full transaction from one requester; response compared against the queue
   task automatic do_txn(input int id, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic hit, input logic [31:0] crd,
                         input logic [31:0] memrd, input int lat, output int latency);
      int n, acc;
      logic [SB_W-1:0]  e;
      logic [N_REQ-1:0] oh;
      latency = -1;
      @(negedge clk);
      bus.c_hit   = hit;
      bus.c_rdata = crd;
      mem_lat     = lat;
      mem_word    = memrd;
      bus.req_valid[id]                  = 1'b1;
      bus.req_write[id]                  = wr;
      bus.req_addr[id*ADDR_W +: ADDR_W]  = addr;
      bus.req_wdata[id*DATA_W +: DATA_W] = wdata;
      #1;
      n = 0;
      while (!bus.req_ready[id] && n < 50) begin
         @(negedge clk); #1; n++;
      end
      if (!bus.req_ready[id]) begin
         checks++; failures++;
         $display("FAIL accept_timeout req%0d: req_ready=%b, required bit %0d set", id, bus.req_ready, id);
         bus.req_valid[id] = 1'b0;
         return;
      end
      acc = cyc;
      exp_q.push_back({~wr, 2'(id), wr ? 32'h0 : (hit ? crd : memrd)});
      exp_ptr = (id + 1) % N_REQ;
      @(negedge clk);
      bus.req_valid[id] = 1'b0;
      #1;
      n = 0;
      while (!bus.rsp_valid[id] && n < 100) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (!bus.rsp_valid[id]) begin
         failures++;
         $display("FAIL rsp_timeout req%0d: rsp_valid=%b after %0d cycles", id, bus.rsp_valid, n);
         void'(exp_q.pop_back());
         return;
      end
      latency = cyc - acc;
      e  = exp_q.pop_front();
      oh = '0;
      oh[e[DATA_W +: 2]] = 1'b1;
      if (bus.rsp_valid !== oh || (e[SB_W-1] && bus.rsp_rdata !== e[DATA_W-1:0])) begin
         failures++;
         $display("FAIL rsp_data req%0d: rsp_valid=%b rdata=%h, required %b %h", id,
                  bus.rsp_valid, bus.rsp_rdata, oh, e[DATA_W-1:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (dbg_state !== IDLE || all_outputs() !== '0) begin
         failures++;
         $display("FAIL reset_state: state=%0d outputs=%h, required IDLE and 0", dbg_state, all_outputs());
      end
      rst = 1'b0;
      exp_ptr = 0;
   endtask

   task automatic test_read_miss_hit();
      int lat, b_fill, b_mem, b_we;
      logic [31:0] fd;
      b_fill = n_c_fill; b_mem = n_mem_req; b_we = n_mem_we;
      do_txn(0, 1'b0, 32'h040, 32'h0, 1'b0, 32'h1111_2222, 32'hDEAD_BEEF, 3, lat);
      fd = fill_data;
      checks++;
      if (lat !== 6) begin failures++; $display("FAIL miss_latency: got %0d, required 6", lat); end
      checks++;
      if (n_c_fill - b_fill !== 1 || fd !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL miss_fill: fills=%0d data=%h, required 1 DEADBEEF", n_c_fill - b_fill, fd);
      end
      checks++;
      if (n_mem_req - b_mem !== 3 || n_mem_we - b_we !== 0 || mem_addr_seen !== 12'h040) begin
         failures++;
         $display("FAIL miss_mem: req_cycles=%0d we_cycles=%0d addr=%h, required 3 0 040",
                  n_mem_req - b_mem, n_mem_we - b_we, mem_addr_seen);
      end
      b_fill = n_c_fill; b_mem = n_mem_req;
      do_txn(0, 1'b0, 32'h040, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'h5555_AAAA, 3, lat);
      checks++;
      if (lat !== 2 || n_mem_req - b_mem !== 0 || n_c_fill - b_fill !== 0) begin
         failures++;
         $display("FAIL hit_path: latency=%0d mem_cycles=%0d fills=%0d, required 2 0 0",
                  lat, n_mem_req - b_mem, n_c_fill - b_fill);
      end
   endtask

   task automatic test_reset_mid_mem();
      int n, b_rsp;
      @(negedge clk);
      bus.c_hit = 1'b0;
      mem_lat   = 5;
      mem_word  = 32'hCAFE_0001;
      bus.req_valid[0]          = 1'b1;
      bus.req_write[0]          = 1'b0;
      bus.req_addr[0 +: ADDR_W] = 32'h0000_0ABC;
      #1;
      n = 0;
      while (!bus.req_ready[0] && n < 20) begin @(negedge clk); #1; n++; end
      @(negedge clk);
      bus.req_valid[0] = 1'b0;
      #1;
      n = 0;
      while (!bus.mem_req && n < 20) begin @(negedge clk); #1; n++; end
      checks++;
      if (!bus.mem_req || dbg_state !== MEM_RD) begin
         failures++;
         $display("FAIL reach_mem_rd: mem_req=%b state=%0d, required 1 MEM_RD", bus.mem_req, dbg_state);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (bus.mem_req !== 1'b0 || dbg_state !== IDLE || all_outputs() !== '0) begin
         failures++;
         $display("FAIL reset_mid_mem: mem_req=%b state=%0d outputs=%h, required 0 IDLE 0",
                  bus.mem_req, dbg_state, all_outputs());
      end
      @(negedge clk);
      rst = 1'b0;
      exp_ptr = 0;
      b_rsp = n_rsp;
      repeat (8) @(negedge clk);
      checks++;
      if (n_rsp - b_rsp !== 0 || dbg_state !== IDLE) begin
         failures++;
         $display("FAIL abandoned_txn: rsp pulses=%0d state=%0d, required 0 IDLE", n_rsp - b_rsp, dbg_state);
      end
   endtask

   task automatic test_stats();
      int lat;
      for (int k = 0; k < 3; k++)
         do_txn(k % 2, 1'b0, 32'h200 + 32'(k), 32'h0, 1'b1, $urandom, 32'h0, 1, lat);
      for (int k = 0; k < 2; k++)
         do_txn(k % 2, 1'b0, 32'h300 + 32'(k), 32'h0, 1'b0, 32'h0, $urandom, $urandom_range(1, 4), lat);
`ifdef CACHE_ACCESS_STATS_EN
      checks++;
      if (bus.hit_cnt !== 16'd3 || bus.miss_cnt !== 16'd2) begin
         failures++;
         $display("FAIL stats_count: hit=%0d miss=%0d, required 3 2", bus.hit_cnt, bus.miss_cnt);
      end
      @(negedge clk);
      force dut.hit_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.hit_cnt_q;
      do_txn(0, 1'b0, 32'h210, 32'h0, 1'b1, 32'h7, 32'h0, 1, lat);
      checks++;
      if (bus.hit_cnt !== 16'hFFFF) begin
         failures++;
         $display("FAIL stats_saturate: hit=%h, required FFFF", bus.hit_cnt);
      end
`else
      checks++;
      if (bus.hit_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin
         failures++;
         $display("FAIL stats_absent: hit=%0d miss=%0d, required 0 0", bus.hit_cnt, bus.miss_cnt);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int n, cnt0, cnt1, prev;
      logic [N_REQ-1:0] oh;
      logic [SB_W-1:0]  e;
      logic [31:0]      crd;
      cnt0 = 0; cnt1 = 0; prev = -1;
      crd = 32'hA5A5_0000 | 32'($urandom_range(0, 65535));
      @(negedge clk);
      bus.c_hit   = 1'b1;
      bus.c_rdata = crd;
      bus.req_write = '0;
      bus.req_addr  = {32'h0000_0200, 32'h0000_0100};
      bus.req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         n = 0;
         while (bus.req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
         oh = '0;
         oh[exp_ptr] = 1'b1;
         checks++;
         if (bus.req_ready !== oh || (prev >= 0 && bus.req_ready[prev])) begin
            failures++;
            $display("FAIL rr_grant%0d: req_ready=%b, required %b", k, bus.req_ready, oh);
         end
         if (bus.req_ready[0]) cnt0++;
         if (bus.req_ready[1]) cnt1++;
         prev = exp_ptr;
         exp_q.push_back({1'b1, 2'(exp_ptr), crd});
         exp_ptr = (exp_ptr + 1) % N_REQ;
         @(negedge clk);
         if (k == 3) bus.req_valid = '0;
         #1;
         n = 0;
         while (bus.rsp_valid == '0 && n < 20) begin @(negedge clk); #1; n++; end
         e  = exp_q.pop_front();
         oh = '0;
         oh[e[DATA_W +: 2]] = 1'b1;
         checks++;
         if (bus.rsp_valid !== oh || bus.rsp_rdata !== e[DATA_W-1:0]) begin
            failures++;
            $display("FAIL rr_rsp%0d: rsp_valid=%b rdata=%h, required %b %h", k,
                     bus.rsp_valid, bus.rsp_rdata, oh, e[DATA_W-1:0]);
         end
         @(negedge clk);
      end
      checks++;
      if (cnt0 !== 2 || cnt1 !== 2) begin
         failures++;
         $display("FAIL rr_fairness: grants req0=%0d req1=%0d, required 2 2", cnt0, cnt1);
      end
   endtask

   task automatic test_write();
      int lat, b_wr, b_fill, b_mem, b_we;
      logic [31:0] wd;
      b_wr = n_c_wr; b_fill = n_c_fill; b_mem = n_mem_req; b_we = n_mem_we;
      do_txn(1, 1'b1, 32'h1040, 32'h1234, 1'b1, 32'h0, 32'h0, 2, lat);
      wd = c_wr_data;
      checks++;
      if (lat !== 4 || n_c_wr - b_wr !== 1 || wd !== 32'h1234 || n_c_fill - b_fill !== 0) begin
         failures++;
         $display("FAIL write_hit: latency=%0d c_wr=%0d data=%h fills=%0d, required 4 1 1234 0",
                  lat, n_c_wr - b_wr, wd, n_c_fill - b_fill);
      end
      checks++;
      if (n_mem_we - b_we !== 2 || n_mem_req - b_mem !== 2 || mem_addr_seen !== 12'h040 ||
          mem_wdata_seen !== 32'h1234) begin
         failures++;
         $display("FAIL write_mem: we_cycles=%0d req_cycles=%0d addr=%h wdata=%h, required 2 2 040 1234",
                  n_mem_we - b_we, n_mem_req - b_mem, mem_addr_seen, mem_wdata_seen);
      end
      b_wr = n_c_wr; b_fill = n_c_fill;
      do_txn(1, 1'b1, 32'h1040, 32'h4321, 1'b0, 32'h0, 32'h0, 1, lat);
      checks++;
      if (lat !== 3 || n_c_wr - b_wr !== 0 || n_c_fill - b_fill !== 0) begin
         failures++;
         $display("FAIL write_miss: latency=%0d c_wr=%0d fills=%0d, required 3 0 0",
                  lat, n_c_wr - b_wr, n_c_fill - b_fill);
      end
   endtask

   task automatic test_addr_wrap();
      int lat;
      do_txn(1, 1'b0, 32'hFFFF_F003, 32'h0, 1'b0, 32'h0, 32'h0BAD_F00D, 1, lat);
      checks++;
      if (mem_addr_seen !== 12'h003 || lat !== 4) begin
         failures++;
         $display("FAIL addr_wrap: mem_addr=%h latency=%0d, required 003 4", mem_addr_seen, lat);
      end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.c_hit     = 1'b0;
      bus.c_rdata   = '0;
      test_reset();
      test_read_miss_hit();
      test_reset_mid_mem();
      test_stats();
      test_back_to_back();
      test_write();
      test_addr_wrap();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog");
   end

endmodule
